irq_ctrl: RTL and testbench

- Prioritised, nestable interrupt controller for the pdp11 core's 8-line interrupt handshake (int_reqs / int_ack).
- Takes raw peripheral and pin interrupt sources, then synchronises, polarity-corrects, edge/level-qualifies, masks and arbitrates them.
- Presents exactly one request at a time to the CPU and tracks in-service state until software writes end-of-interrupt.
- Sits between the I/O peripherals (timers, UART, SPI, PORTA pins) and the core; registers are accessed over the core's 8-bit io_addr bus.

---
 rtl/irq_ctrl_pkg.sv | 30 +++
 rtl/irq_ctrl_src_cond.sv | 39 +++
 rtl/irq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_irq_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared definitions for the irq_ctrl interrupt controller.
//   - register offsets within the 8-word io_addr window
//   - arbiter FSM state encoding
//   - prio_idx(): index of the highest-priority (lowest-numbered) set bit
package irq_ctrl_pkg;

    localparam logic [2:0] OFS_MASK   = 3'd0;
    localparam logic [2:0] OFS_MODE   = 3'd1;
    localparam logic [2:0] OFS_POL    = 3'd2;
    localparam logic [2:0] OFS_PEND   = 3'd3;
    localparam logic [2:0] OFS_ISR    = 3'd4;
    localparam logic [2:0] OFS_STAT   = 3'd5;
    localparam logic [2:0] OFS_SWTRIG = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // Returns 0 when no bit is set; callers qualify with |v.
    function automatic logic [2:0] prio_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_ctrl_src_cond.sv
// irq_src_cond: conditioning for one interrupt source.
//   clk, rst_n : clock, async active-low reset
//   src        : raw asynchronous source
//   pol        : 1 = source is active-low
//   lvl        : synchronised, polarity-corrected active-high level
//   rise       : one-cycle pulse on a rising edge of lvl
module irq_src_cond (
    input  logic clk,
    input  logic rst_n,
    input  logic src,
    input  logic pol,
    output logic lvl,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    // prev holds the raw synchronised level; resetting it to one keeps a
    // source sitting at its idle level at reset release from looking like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b1;
        end else begin
            meta <= src;
            sync <= meta;
            prev <= sync;
        end
    end

    assign lvl = sync ^ pol;
    // Both samples are corrected with the current polarity, so rewriting POL
    // never fabricates an edge on its own.
    assign rise = lvl & ~(prev ^ pol);

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: prioritised, nestable interrupt controller for the pdp11 core.
// Optional feature macro: IRQ_CTRL_SWTRIG_EN (offset 6 becomes a software
// trigger register that sets PEND for edge-mode sources).
//   wb_clk_i  : clock
//   rst_n     : async active-low reset
//   src_in    : raw asynchronous interrupt sources
//   io_addr   : core I/O address; io_wdata/io_wen : write data / strobe
//   io_rdata  : registered read data; io_rsel : registered window hit
//   int_reqs  : one-hot request to the core; int_ack : one-hot acknowledge
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int         NUM_SRC   = 8,
    parameter logic [7:0] BASE_ADDR = 8'd32
) (
    input  logic               wb_clk_i,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic [7:0]         io_addr,
    input  logic [15:0]        io_wdata,
    input  logic               io_wen,
    output logic [15:0]        io_rdata,
    output logic               io_rsel,
    output logic [NUM_SRC-1:0] int_reqs,
    input  logic [NUM_SRC-1:0] int_ack
);

    localparam logic [7:0] VALID = 8'((9'd1 << NUM_SRC) - 9'd1);

    logic [7:0] mask_r, mode_r, pol_r, pend_r, isr_r;
    logic [7:0] src_pad, ack_pad, lvl, rise;
    logic [7:0] req_r;
    logic [2:0] req_idx;
    state_t     state;

    always_comb begin
        src_pad = '0;
        ack_pad = '0;
        src_pad[NUM_SRC-1:0] = src_in;
        ack_pad[NUM_SRC-1:0] = int_ack;
    end

    for (genvar g = 0; g < 8; g++) begin : g_src
        if (g < NUM_SRC) begin : g_used
            irq_src_cond u_cond (
                .clk  (wb_clk_i),
                .rst_n(rst_n),
                .src  (src_pad[g]),
                .pol  (pol_r[g]),
                .lvl  (lvl[g]),
                .rise (rise[g])
            );
        end else begin : g_tie
            assign lvl[g]  = 1'b0;
            assign rise[g] = 1'b0;
        end
    end

    // Register window decode; modulo-256 subtraction makes the range check one compare.
    logic [7:0] ofs8;
    logic [2:0] ofs;
    logic       hit, wr;
    logic       unused_wdata_hi;

    assign ofs8            = io_addr - BASE_ADDR;
    assign hit             = (ofs8 < 8'd8);
    assign ofs             = ofs8[2:0];
    assign wr              = io_wen & hit;
    assign unused_wdata_hi = ^io_wdata[15:8];

    logic [7:0] w1c_pend, w1c_isr, swtrig;
    assign w1c_pend = (wr && ofs == OFS_PEND) ? io_wdata[7:0] : 8'h00;
    assign w1c_isr  = (wr && ofs == OFS_ISR)  ? io_wdata[7:0] : 8'h00;
`ifdef IRQ_CTRL_SWTRIG_EN
    assign swtrig   = (wr && ofs == OFS_SWTRIG) ? (io_wdata[7:0] & mode_r) : 8'h00;
`else
    assign swtrig   = 8'h00;
`endif

    // Only sources strictly above the highest-priority in-service one may be requested.
    logic [7:0] allowed, elig;
    assign allowed = (isr_r == 8'h00) ? 8'hFF : ((8'd1 << prio_idx(isr_r)) - 8'd1);
    assign elig    = pend_r & mask_r & ~isr_r & allowed & VALID;

    logic       ack_hit;
    logic [7:0] ack_vec;
    assign ack_hit = (state == REQ) && ack_pad[req_idx];
    assign ack_vec = ack_hit ? (8'd1 << req_idx) : 8'h00;

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            req_idx <= 3'd0;
            req_r   <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (|elig) begin
                        req_idx <= prio_idx(elig);
                        req_r   <= 8'd1 << prio_idx(elig);
                        state   <= REQ;
                    end
                end
                REQ: begin
                    // Higher-priority arrivals wait for the next IDLE pass.
                    if (ack_hit || !elig[req_idx]) begin
                        req_idx <= 3'd0;
                        req_r   <= 8'h00;
                        state   <= IDLE;
                    end
                end
                default: begin
                    req_idx <= 3'd0;
                    req_r   <= 8'h00;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign int_reqs = req_r[NUM_SRC-1:0];

    // Edge sources: set beats clear. Level sources simply follow lvl.
    logic [7:0] pend_set, pend_clr, pend_edge;
    assign pend_set  = (rise & mode_r) | swtrig;
    assign pend_clr  = w1c_pend | ack_vec;
    assign pend_edge = pend_set | (pend_r & ~pend_clr);

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            mask_r <= 8'h00;
            mode_r <= 8'h00;
            pol_r  <= 8'h00;
            pend_r <= 8'h00;
            isr_r  <= 8'h00;
        end else begin
            if (wr && ofs == OFS_MASK) mask_r <= io_wdata[7:0] & VALID;
            if (wr && ofs == OFS_MODE) mode_r <= io_wdata[7:0] & VALID;
            if (wr && ofs == OFS_POL)  pol_r  <= io_wdata[7:0] & VALID;
            pend_r <= ((pend_edge & mode_r) | (lvl & ~mode_r)) & VALID;
            isr_r  <= ((isr_r & ~w1c_isr) | ack_vec) & VALID;
        end
    end

    logic [15:0] rd_word;
    always_comb begin
        rd_word = 16'hFFFF;
        case (ofs)
            OFS_MASK:   rd_word = {8'h00, mask_r};
            OFS_MODE:   rd_word = {8'h00, mode_r};
            OFS_POL:    rd_word = {8'h00, pol_r};
            OFS_PEND:   rd_word = {8'h00, pend_r};
            OFS_ISR:    rd_word = {8'h00, isr_r};
            OFS_STAT:   rd_word = {8'h00, (state == REQ), 4'b0000, req_idx};
`ifdef IRQ_CTRL_SWTRIG_EN
            OFS_SWTRIG: rd_word = 16'h0000;
`endif
            default:    rd_word = 16'hFFFF;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            io_rdata <= 16'h0000;
            io_rsel  <= 1'b0;
        end else begin
            io_rsel <= hit;
            if (hit) io_rdata <= rd_word;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl (NUM_SRC=8, BASE_ADDR=32).
module tb_irq_ctrl;

    localparam logic [7:0] BASE = 8'd32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  src_in;
    logic [7:0]  io_addr;
    logic [15:0] io_wdata;
    logic        io_wen;
    logic [15:0] io_rdata;
    logic        io_rsel;
    logic [7:0]  int_reqs;
    logic [7:0]  int_ack;

    int n_cmp = 0;
    int n_bad = 0;

    irq_ctrl #(.NUM_SRC(8), .BASE_ADDR(BASE)) dut (
        .wb_clk_i(clk),
        .rst_n   (rst_n),
        .src_in  (src_in),
        .io_addr (io_addr),
        .io_wdata(io_wdata),
        .io_wen  (io_wen),
        .io_rdata(io_rdata),
        .io_rsel (io_rsel),
        .int_reqs(int_reqs),
        .int_ack (int_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] ofs, input logic [15:0] d);
        io_addr  = BASE + 8'(ofs);
        io_wdata = d;
        io_wen   = 1'b1;
        tick();
        io_wen   = 1'b0;
        io_addr  = 8'h00;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] ofs, input logic [15:0] exp);
        io_addr = BASE + 8'(ofs);
        tick();
        check(tag, io_rdata, exp);
        io_addr = 8'h00;
    endtask

    task automatic wait_req(input string tag, input logic [7:0] exp);
        for (int i = 0; i < 20; i++) begin
            if (int_reqs != 8'h00) break;
            tick();
        end
        check(tag, int_reqs, exp);
    endtask

    task automatic ack(input logic [7:0] v);
        int_ack = v;
        tick();
        int_ack = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        src_in   = 8'h00;
        io_addr  = 8'h00;
        io_wdata = 16'h0000;
        io_wen   = 1'b0;
        int_ack  = 8'h00;

        // Reset state
        #12;
        check("rst_int_reqs", int_reqs, 8'h00);
        check("rst_rdata", io_rdata, 16'h0000);
        check("rst_rsel", io_rsel, 1'b0);
        rst_n = 1'b1;
        tick();
        rd_chk("rst_mask", 3'd0, 16'h0000);

        // Single edge pulse on src 0: request 3 cycles after sampling
        wr(3'd0, 16'h0001);
        wr(3'd1, 16'h0001);
        src_in = 8'h01;
        tick();
        src_in = 8'h00;
        tick();
        check("t1_lat_k1", int_reqs, 8'h00);
        tick();
        check("t1_lat_k2", int_reqs, 8'h00);
        tick();
        check("t1_lat_k3", int_reqs, 8'h01);
        ack(8'h01);
        check("t1_after_ack", int_reqs, 8'h00);
        rd_chk("t1_pend", 3'd3, 16'h0000);
        rd_chk("t1_isr", 3'd4, 16'h0001);
        wr(3'd4, 16'h0001);

        // Nesting: ISR[3] blocks src 5 but not src 1
        wr(3'd0, 16'h002A);
        wr(3'd1, 16'h002A);
        src_in = 8'h08;
        wait_req("t2_req3", 8'h08);
        ack(8'h08);
        src_in = 8'h2A;
        wait_req("t2_req1", 8'h02);
        ack(8'h02);
        tick();
        tick();
        check("t2_blocked", int_reqs, 8'h00);
        rd_chk("t2_pend5", 3'd3, 16'h0020);
        wr(3'd4, 16'h0008);
        tick();
        check("t2_still_blocked", int_reqs, 8'h00);
        wr(3'd4, 16'h0002);
        wait_req("t2_req5", 8'h20);
        ack(8'h20);
        wr(3'd4, 16'h0020);
        src_in = 8'h00;
        rd_chk("t2_isr_clear", 3'd4, 16'h0000);

        // Level source 2: re-request one cycle after EOI, PEND follows drop
        wr(3'd0, 16'h0004);
        wr(3'd1, 16'h0000);
        src_in = 8'h04;
        wait_req("t3_req2", 8'h04);
        ack(8'h04);
        tick();
        tick();
        check("t3_in_service", int_reqs, 8'h00);
        wr(3'd4, 16'h0004);
        check("t3_eoi_cycle", int_reqs, 8'h00);
        tick();
        check("t3_rereq", int_reqs, 8'h04);
        ack(8'h04);
        src_in = 8'h00;
        tick();
        tick();
        tick();
        rd_chk("t3_pend_drop", 3'd3, 16'h0000);
        wr(3'd4, 16'h0004);
        tick();
        check("t3_idle", int_reqs, 8'h00);

        // Mask write while in REQ for idx 4
        wr(3'd0, 16'h0010);
        wr(3'd1, 16'h0010);
        src_in = 8'h10;
        wait_req("t4_req4", 8'h10);
        rd_chk("t4_stat_req", 3'd5, 16'h0084);
        wr(3'd0, 16'h0000);
        check("t4_mask_edge", int_reqs, 8'h10);
        tick();
        check("t4_dropped", int_reqs, 8'h00);
        rd_chk("t4_isr", 3'd4, 16'h0000);
        rd_chk("t4_stat_idle", 3'd5, 16'h0000);
        wr(3'd3, 16'h0010);
        rd_chk("t4_pend_w1c", 3'd3, 16'h0000);
        src_in = 8'h00;

        // Reset while requesting drops int_reqs without a clock edge
        wr(3'd0, 16'h0040);
        src_in = 8'h40;
        wait_req("t5_req6", 8'h40);
        rst_n = 1'b0;
        #2;
        check("t5_async_drop", int_reqs, 8'h00);
        src_in = 8'h00;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        rd_chk("t5_mask_rst", 3'd0, 16'h0000);

        // Active-low src 7 idle low: level mode sees it pending
        wr(3'd2, 16'h0080);
        tick();
        rd_chk("t6_pol_level", 3'd3, 16'h0080);

        // Edge mode: needs a high-then-low sequence
        do_reset();
        wr(3'd1, 16'h0080);
        wr(3'd2, 16'h0080);
        wr(3'd0, 16'h0080);
        for (int i = 0; i < 4; i++) tick();
        check("t6_edge_quiet", int_reqs, 8'h00);
        rd_chk("t6_edge_pend", 3'd3, 16'h0000);
        src_in = 8'h80;
        for (int i = 0; i < 4; i++) tick();
        check("t6_inactive_high", int_reqs, 8'h00);
        src_in = 8'h00;
        wait_req("t6_edge_req", 8'h80);
        ack(8'h80);
        wr(3'd4, 16'h0080);

        // Window edges and unused offsets
        io_addr = BASE + 8'd7;
        tick();
        check("t7_ofs7_data", io_rdata, 16'hFFFF);
        check("t7_ofs7_rsel", io_rsel, 1'b1);
        io_addr = BASE + 8'd8;
        tick();
        check("t7_ofs8_rsel", io_rsel, 1'b0);
        check("t7_ofs8_hold", io_rdata, 16'hFFFF);
        io_addr = 8'h00;
        wr(3'd0, 16'hFFFF);
        rd_chk("t7_mask_hi_zero", 3'd0, 16'h00FF);
        wr(3'd0, 16'h0000);
`ifdef IRQ_CTRL_SWTRIG_EN
        rd_chk("t8_swtrig_read", 3'd6, 16'h0000);
        wr(3'd1, 16'h0040);
        wr(3'd0, 16'h0040);
        wr(3'd6, 16'h0040);
        wait_req("t8_swtrig_req", 8'h40);
`else
        rd_chk("t8_ofs6_read", 3'd6, 16'hFFFF);
        wr(3'd6, 16'h0040);
        rd_chk("t8_ofs6_nop", 3'd3, 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
